// File: rtl/pre_if_fetch_unit.sv
// Pre-IF fetch unit: credit-limited inst_sram requester with redirect/drop handling and a fetched-instruction FIFO.
// Optional perf counters are built only when PFU_PERF_CNT_EN is defined.
module pre_if_fetch_unit #(
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 4,
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY    = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  output logic        pfs_to_fs_valid,
  output logic [63:0] pfs_to_fs_bus,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_data_ok,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);
  localparam int IW = $clog2(OUTSTANDING + 1);
  localparam int QW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int FW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic          started;
  logic [31:0]   pc;
  logic [31:0]   target;
  logic [IW-1:0] inflight, drop_cnt;
  logic [31:0]   pc_q [OUTSTANDING];
  logic [QW-1:0] q_wr, q_rd;
  logic [63:0]   fifo [BUF_DEPTH];
  logic [FW-1:0] f_wr, f_rd;
  logic [CW-1:0] f_cnt;
  logic          redirect, accept, dok, keep, discard, pop;

  function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
    return (p == QW'(OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  assign redirect = ws_ex | ws_eret | br_taken;

  always_comb begin
    target = br_target;
    if (ws_ex)        target = EX_ENTRY;
    else if (ws_eret) target = cp0_epc;
  end

  // Credit rule: only request when the response is guaranteed a FIFO slot.
  assign inst_sram_req  = started && !redirect && (int'(inflight) < OUTSTANDING) &&
                          (int'(inflight) + int'(f_cnt) < BUF_DEPTH);
  assign inst_sram_addr = {pc[31:2], 2'b00};

  assign accept  = inst_sram_req && inst_sram_addr_ok;
  assign dok     = inst_sram_data_ok && (inflight != '0);
  assign keep    = dok && (drop_cnt == '0) && !redirect;
  assign discard = dok && !keep;

  assign pfs_to_fs_valid = (f_cnt != '0);
  assign pfs_to_fs_bus   = pfs_to_fs_valid ? fifo[f_rd] : '0;
  assign pop             = pfs_to_fs_valid && fs_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started  <= 1'b0;
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      f_wr     <= '0;
      f_rd     <= '0;
      f_cnt    <= '0;
    end else begin
      started <= 1'b1;
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + 32'd4;
      if (accept) q_wr <= qnext(q_wr);
      if (dok)    q_rd <= qnext(q_rd);
      inflight <= inflight + IW'(accept) - IW'(dok);
      // Every request still outstanding after a redirect belongs to the old stream.
      if (redirect)     drop_cnt <= inflight - IW'(dok);
      else if (discard) drop_cnt <= drop_cnt - IW'(1);
      if (redirect) begin
        f_cnt <= '0;
        f_rd  <= f_wr;
      end else begin
        if (keep) f_wr <= f_wr + FW'(1);
        if (pop)  f_rd <= f_rd + FW'(1);
        f_cnt <= f_cnt + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_q[q_wr] <= pc;
    if (keep)   fifo[f_wr] <= {inst_sram_rdata, pc_q[q_rd]};
  end

`ifdef PFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (keep)    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif
endmodule
